turn_timeout_ctrl: RTL and testbench

Per-move time-limit controller sitting directly downstream of Timer1ms in the two-player memory game. It drives the timer's Start input and consumes its 21-bit millisecond count T. It flags a warning and a timeout when a player takes too long between presses, and accumulates per-player total thinking time for the score display. The game controller owns turn sequencing; this block only times moves.

---
 rtl/game_pkg.sv | 26 ++
 rtl/player_time_acc.sv | 61 ++++++
 rtl/turn_timeout_ctrl.sv | 166 ++++++++++++++++
 tb/tb_turn_timeout_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the memory-game move timing logic: the turn-timer
// state encoding and the default widths/thresholds used by the turn timeout
// controller, the game controller and the score display.
// ---------------------------------------------------------------------------
package game_pkg;

  // Turn-timer state.
  // IDLE    : no move being timed, timer held clear
  // CLEAR   : one-cycle timer clear before a new window
  // RUN     : timer counting the current move
  // EXPIRED : move ran out of time, waits for a new turn or abort
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } turn_state_e;

  localparam int T_WIDTH_DEF   = 21;
  localparam int ACC_WIDTH_DEF = 24;
  localparam int LIMIT_MS_DEF  = 5000;
  localparam int WARN_MS_DEF   = 4000;

endpackage

// File: rtl/player_time_acc.sv
// ---------------------------------------------------------------------------
// player_time_acc
// Saturating accumulator of one player's accepted thinking time.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset, clears the total
//   clr_i     : synchronous clear, wins over a same-cycle add
//   add_en_i  : add add_val_i to the total this cycle
//   add_val_i : unsigned addend (ms), zero-extended before the add
//   total_o   : registered running total, sticks at all-ones on overflow
// ---------------------------------------------------------------------------
module player_time_acc #(
  parameter int ACC_WIDTH = 24,
  parameter int ADD_WIDTH = 21
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 add_en_i,
  input  logic [ADD_WIDTH-1:0] add_val_i,
  output logic [ACC_WIDTH-1:0] total_o
);

  // One bit wider than the larger operand so the carry is never lost.
  localparam int SUM_W = ((ACC_WIDTH > ADD_WIDTH) ? ACC_WIDTH : ADD_WIDTH) + 1;
  localparam logic [SUM_W-1:0] SAT_VAL = SUM_W'({ACC_WIDTH{1'b1}});

  logic [ACC_WIDTH-1:0] total_q;
  logic [ACC_WIDTH-1:0] total_d;

  function automatic logic [ACC_WIDTH-1:0] sat_add(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [ADD_WIDTH-1:0] val
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(val);
    if (sum > SAT_VAL) begin
      return {ACC_WIDTH{1'b1}};
    end
    return sum[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    total_d = total_q;
    if (clr_i) begin
      total_d = '0;
    end else if (add_en_i) begin
      total_d = sat_add(total_q, add_val_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_o = total_q;

endmodule

// File: rtl/turn_timeout_ctrl.sv
// ---------------------------------------------------------------------------
// turn_timeout_ctrl
// Per-move time-limit controller placed after the 1 ms timer. It runs and
// clears the timer through Start, raises Warn when a move gets long, pulses
// Timeout when the move limit is reached, and totals each player's accepted
// thinking time.
//   Clk          : system clock (rising edge)
//   Rst          : asynchronous active-low reset
//   TurnBegin    : pulse, start timing a new turn for TurnPlayer
//   TurnPlayer   : player index, sampled with TurnBegin
//   PressValid   : pulse, current player pressed a button
//   LastPress    : qualifies PressValid as the final press of the sequence
//   Abort        : level, return to IDLE without accumulating
//   ClrTotals    : pulse, clear both player totals
//   T            : elapsed ms from the timer
//   Start        : registered timer run (1) / clear (0)
//   Warn         : registered, RUN and T >= WARN_MS seen last cycle
//   Timeout      : pulse, move expired
//   TurnDone     : pulse, final press accepted in time
//   ActivePlayer : player latched at TurnBegin
//   TimeUsed     : T captured at the latest accepted press
//   Total0/1     : per-player accumulated accepted-press time
// ---------------------------------------------------------------------------
module turn_timeout_ctrl
  import game_pkg::*;
#(
  parameter int T_WIDTH   = T_WIDTH_DEF,
  parameter int LIMIT_MS  = LIMIT_MS_DEF,
  parameter int WARN_MS   = WARN_MS_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 TurnBegin,
  input  logic                 TurnPlayer,
  input  logic                 PressValid,
  input  logic                 LastPress,
  input  logic                 Abort,
  input  logic                 ClrTotals,
  input  logic [T_WIDTH-1:0]   T,
  output logic                 Start,
  output logic                 Warn,
  output logic                 Timeout,
  output logic                 TurnDone,
  output logic                 ActivePlayer,
  output logic [T_WIDTH-1:0]   TimeUsed,
  output logic [ACC_WIDTH-1:0] Total0,
  output logic [ACC_WIDTH-1:0] Total1
);

  localparam logic [T_WIDTH-1:0] LIMIT_T = T_WIDTH'(LIMIT_MS);
  localparam logic [T_WIDTH-1:0] WARN_T  = T_WIDTH'(WARN_MS);

  turn_state_e        state_q;
  logic               start_q;
  logic               warn_q;
  logic               timeout_q;
  logic               done_q;
  logic               player_q;
  logic [T_WIDTH-1:0] used_q;

  logic in_run;
  logic expire;
  logic accept;
  logic acc_en0;
  logic acc_en1;

  // Abort and TurnBegin pre-empt whatever RUN would do this cycle; expiry
  // beats a press arriving on the same edge.
  always_comb begin
    in_run  = (state_q == RUN) && !Abort && !TurnBegin;
    expire  = in_run && (T >= LIMIT_T);
    accept  = in_run && PressValid && (T < LIMIT_T);
    acc_en0 = accept && !player_q;
    acc_en1 = accept &&  player_q;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      warn_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      player_q  <= 1'b0;
      used_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      // Warn looks at the state and T of the cycle just ending.
      warn_q    <= (state_q == RUN) && (T >= WARN_T);

      if (Abort) begin
        state_q <= IDLE;
        start_q <= 1'b0;
      end else if (TurnBegin) begin
        state_q  <= CLEAR;
        start_q  <= 1'b0;
        player_q <= TurnPlayer;
      end else begin
        case (state_q)
          CLEAR: begin
            state_q <= RUN;
            start_q <= 1'b1;
          end
          RUN: begin
            if (expire) begin
              state_q   <= EXPIRED;
              start_q   <= 1'b0;
              timeout_q <= 1'b1;
            end else if (accept) begin
              used_q  <= T;
              start_q <= 1'b0;
              if (LastPress) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                // Another press follows: one Start-low cycle zeroes T.
                state_q <= CLEAR;
              end
            end
          end
          IDLE, EXPIRED: begin
            start_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  player_time_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .ADD_WIDTH (T_WIDTH)
  ) u_acc0 (
    .clk_i     (Clk),
    .rst_ni    (Rst),
    .clr_i     (ClrTotals),
    .add_en_i  (acc_en0),
    .add_val_i (T),
    .total_o   (Total0)
  );

  player_time_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .ADD_WIDTH (T_WIDTH)
  ) u_acc1 (
    .clk_i     (Clk),
    .rst_ni    (Rst),
    .clr_i     (ClrTotals),
    .add_en_i  (acc_en1),
    .add_val_i (T),
    .total_o   (Total1)
  );

  assign Start        = start_q;
  assign Warn         = warn_q;
  assign Timeout      = timeout_q;
  assign TurnDone     = done_q;
  assign ActivePlayer = player_q;
  assign TimeUsed     = used_q;

endmodule

// File: tb/tb_turn_timeout_ctrl.sv
module tb_turn_timeout_ctrl;

  localparam int TW  = 21;
  localparam int LIM = 10;
  localparam int WRN = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic TurnBegin = 1'b0, TurnPlayer = 1'b0, PressValid = 1'b0;
  logic LastPress = 1'b0, Abort = 1'b0, ClrTotals = 1'b0;
  logic [TW-1:0] T;
  logic [TW-1:0] t_force = '0;
  logic [TW-1:0] t_tmr = '0;
  logic tmode = 1'b0;
  int unsigned div = 0;

  logic Start, Warn, Timeout, TurnDone, ActivePlayer;
  logic [TW-1:0] TimeUsed;
  logic [23:0] Total0, Total1;
  logic s_start, s_warn, s_to, s_done, s_ap;
  logic [TW-1:0] s_used;
  logic [3:0] s_tot0, s_tot1;

  int n_cmp = 0;
  int n_fail = 0;

  turn_timeout_ctrl #(.T_WIDTH(TW), .LIMIT_MS(LIM), .WARN_MS(WRN), .ACC_WIDTH(24)) dut (
    .Clk(Clk), .Rst(Rst), .TurnBegin(TurnBegin), .TurnPlayer(TurnPlayer),
    .PressValid(PressValid), .LastPress(LastPress), .Abort(Abort), .ClrTotals(ClrTotals),
    .T(T), .Start(Start), .Warn(Warn), .Timeout(Timeout), .TurnDone(TurnDone),
    .ActivePlayer(ActivePlayer), .TimeUsed(TimeUsed), .Total0(Total0), .Total1(Total1));

  turn_timeout_ctrl #(.T_WIDTH(TW), .LIMIT_MS(LIM), .WARN_MS(WRN), .ACC_WIDTH(4)) dut_s (
    .Clk(Clk), .Rst(Rst), .TurnBegin(TurnBegin), .TurnPlayer(TurnPlayer),
    .PressValid(PressValid), .LastPress(LastPress), .Abort(Abort), .ClrTotals(ClrTotals),
    .T(T), .Start(s_start), .Warn(s_warn), .Timeout(s_to), .TurnDone(s_done),
    .ActivePlayer(s_ap), .TimeUsed(s_used), .Total0(s_tot0), .Total1(s_tot1));

  always #5 Clk = ~Clk;

  // Behavioural 1 ms timer: held at 0 while Start is low, +1 every 3 clocks otherwise.
  always @(posedge Clk) begin
    if (!Start) begin
      t_tmr <= '0;
      div   <= 0;
    end else if (div == 2) begin
      div   <= 0;
      t_tmr <= t_tmr + 1'b1;
    end else begin
      div <= div + 1;
    end
  end

  assign T = tmode ? t_tmr : t_force;

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int wr, input int to,
                           input int dn, input int ap, input int used, input int t0,
                           input int t1, input int t0s, input int t1s);
    chk({tag, ".Start"},    32'(Start),        st);
    chk({tag, ".Warn"},     32'(Warn),         wr);
    chk({tag, ".Timeout"},  32'(Timeout),      to);
    chk({tag, ".TurnDone"}, 32'(TurnDone),     dn);
    chk({tag, ".Player"},   32'(ActivePlayer), ap);
    chk({tag, ".TimeUsed"}, 32'(TimeUsed),     used);
    chk({tag, ".Total0"},   32'(Total0),       t0);
    chk({tag, ".Total1"},   32'(Total1),       t1);
    chk({tag, ".s.Start"},  32'(s_start),      st);
    chk({tag, ".s.Warn"},   32'(s_warn),       wr);
    chk({tag, ".s.Timeout"},32'(s_to),         to);
    chk({tag, ".s.Done"},   32'(s_done),       dn);
    chk({tag, ".s.Player"}, 32'(s_ap),         ap);
    chk({tag, ".s.Used"},   32'(s_used),       used);
    chk({tag, ".s.Total0"}, 32'(s_tot0),       t0s);
    chk({tag, ".s.Total1"}, 32'(s_tot1),       t1s);
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic quiet();
    TurnBegin = 0; PressValid = 0; LastPress = 0; Abort = 0; ClrTotals = 0;
  endtask

  task automatic begin_turn(input logic pl);
    TurnBegin = 1; TurnPlayer = pl;
    tick();
    quiet();
  endtask

  task automatic wait_t(input int v, input string nm);
    int n = 0;
    while (T != TW'(v) && n < 200) begin
      tick();
      n++;
    end
    chk({nm, ".reached"}, 32'(T == TW'(v)), 1);
  endtask

  // Directed vector table: inputs applied before an edge, outputs expected after it.
  typedef struct {
    int tb, pl, pv, lp, ab, clr, t;
    int st, wr, to, dn, ap, used, t0, t1, t0s, t1s;
  } vec_t;
  vec_t vt[40];
  int nv = 0;

  task automatic row(input int tb_, input int pl_, input int pv_, input int lp_, input int ab_,
                     input int clr_, input int t_, input int st_, input int wr_, input int to_,
                     input int dn_, input int ap_, input int used_, input int t0_, input int t1_,
                     input int t0s_, input int t1s_);
    vt[nv] = '{tb_, pl_, pv_, lp_, ab_, clr_, t_, st_, wr_, to_, dn_, ap_, used_, t0_, t1_, t0s_, t1s_};
    nv++;
  endtask

  // Reference model state.
  bit    m_run, m_clr;
  int    e_ap, e_used, e_warn, e_to, e_done;
  longint sum0, sum1;

  function automatic int sat(input longint s, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return int'((s > mx) ? mx : s);
  endfunction

  task automatic model_step();
    int tv;
    tv = int'(T);
    e_warn = (m_run && tv >= WRN) ? 1 : 0;
    e_to = 0;
    e_done = 0;
    if (Abort) begin
      m_run = 0; m_clr = 0;
    end else if (TurnBegin) begin
      m_run = 0; m_clr = 1; e_ap = int'(TurnPlayer);
    end else if (m_clr) begin
      m_clr = 0; m_run = 1;
    end else if (m_run) begin
      if (tv >= LIM) begin
        m_run = 0; e_to = 1;
      end else if (PressValid) begin
        e_used = tv;
        if (e_ap == 0) sum0 += tv; else sum1 += tv;
        m_run = 0;
        if (LastPress) e_done = 1; else m_clr = 1;
      end
    end
    if (ClrTotals) begin
      sum0 = 0; sum1 = 0;
    end
  endtask

  initial begin
    int prev_t;
    bit seen_warn, seen_to;
    int n_to;

    // ---------------- reset ----------------
    repeat (3) @(negedge Clk);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle.Start", 32'(Start), 0);
      chk("idle.Timeout", 32'(Timeout), 0);
    end

    // ---------------- directed table (T forced) ----------------
    row(1,1,0,0,0,0,0,   0,0,0,0,1,0, 0,0,0,0);
    row(0,0,0,0,0,0,0,   1,0,0,0,1,0, 0,0,0,0);
    row(0,0,1,0,0,0,4,   0,0,0,0,1,4, 0,4,0,4);
    row(0,0,0,0,0,0,0,   1,0,0,0,1,4, 0,4,0,4);
    row(0,0,1,1,0,0,6,   0,0,0,1,1,6, 0,10,0,10);
    row(0,0,0,0,0,0,0,   0,0,0,0,1,6, 0,10,0,10);
    row(0,0,1,1,0,0,3,   0,0,0,0,1,6, 0,10,0,10);
    row(1,0,0,0,0,0,0,   0,0,0,0,0,6, 0,10,0,10);
    row(0,0,0,0,0,0,0,   1,0,0,0,0,6, 0,10,0,10);
    row(0,0,0,0,0,0,8,   1,1,0,0,0,6, 0,10,0,10);
    row(0,0,1,1,0,0,10,  0,1,1,0,0,6, 0,10,0,10);
    row(0,0,1,0,0,0,0,   0,0,0,0,0,6, 0,10,0,10);
    row(1,0,0,0,0,0,0,   0,0,0,0,0,6, 0,10,0,10);
    row(0,0,0,0,0,0,0,   1,0,0,0,0,6, 0,10,0,10);
    row(0,0,1,1,0,1,9,   0,1,0,1,0,9, 0,0,0,0);
    row(1,1,0,0,0,0,0,   0,0,0,0,1,9, 0,0,0,0);
    row(0,0,0,0,0,0,0,   1,0,0,0,1,9, 0,0,0,0);
    row(1,0,0,0,1,0,5,   0,0,0,0,1,9, 0,0,0,0);
    row(0,0,1,0,0,0,12,  0,0,0,0,1,9, 0,0,0,0);
    row(1,0,0,0,0,0,0,   0,0,0,0,0,9, 0,0,0,0);
    row(0,0,0,0,0,0,0,   1,0,0,0,0,9, 0,0,0,0);
    row(0,0,1,0,0,0,9,   0,1,0,0,0,9, 9,0,9,0);
    row(0,0,0,0,0,0,0,   1,0,0,0,0,9, 9,0,9,0);
    row(0,0,1,0,0,0,9,   0,1,0,0,0,9, 18,0,15,0);
    row(0,0,0,0,0,0,0,   1,0,0,0,0,9, 18,0,15,0);
    row(0,0,1,1,0,0,9,   0,1,0,1,0,9, 27,0,15,0);
    row(1,1,0,0,0,0,0,   0,0,0,0,1,9, 27,0,15,0);
    row(0,0,0,0,0,0,0,   1,0,0,0,1,9, 27,0,15,0);
    row(0,0,0,0,0,0,3,   1,0,0,0,1,9, 27,0,15,0);
    row(1,0,1,1,0,0,5,   0,0,0,0,0,9, 27,0,15,0);
    row(0,0,0,0,0,1,0,   1,0,0,0,0,9, 0,0,0,0);
    row(0,0,0,0,0,0,9,   1,1,0,0,0,9, 0,0,0,0);
    row(0,0,0,0,1,0,9,   0,1,0,0,0,9, 0,0,0,0);
    row(0,0,0,0,0,0,0,   0,0,0,0,0,9, 0,0,0,0);

    tmode = 0;
    for (int i = 0; i < nv; i++) begin
      TurnBegin  = (vt[i].tb != 0);
      TurnPlayer = (vt[i].pl != 0);
      PressValid = (vt[i].pv != 0);
      LastPress  = (vt[i].lp != 0);
      Abort      = (vt[i].ab != 0);
      ClrTotals  = (vt[i].clr != 0);
      t_force    = TW'(vt[i].t);
      tick();
      check_all($sformatf("vec%0d", i), vt[i].st, vt[i].wr, vt[i].to, vt[i].dn, vt[i].ap,
                vt[i].used, vt[i].t0, vt[i].t1, vt[i].t0s, vt[i].t1s);
    end
    quiet();
    t_force = '0;

    // ---------------- timer-driven sequences ----------------
    tmode = 1;
    tick();

    // Two presses for player 1 with a restart between them.
    begin_turn(1'b1);
    wait_t(4, "seqA.t4");
    PressValid = 1; LastPress = 0;
    tick();
    quiet();
    chk("seqA.used4", 32'(TimeUsed), 4);
    chk("seqA.tot1_4", 32'(Total1), 4);
    chk("seqA.start_low", 32'(Start), 0);
    tick();
    chk("seqA.start_back", 32'(Start), 1);
    wait_t(6, "seqA.t6");
    PressValid = 1; LastPress = 1;
    tick();
    quiet();
    chk("seqA.used6", 32'(TimeUsed), 6);
    chk("seqA.tot1_10", 32'(Total1), 10);
    chk("seqA.tot0_0", 32'(Total0), 0);
    chk("seqA.done", 32'(TurnDone), 1);
    chk("seqA.start_end", 32'(Start), 0);
    tick();
    chk("seqA.done_pulse", 32'(TurnDone), 0);

    // No press: warning then expiry.
    begin_turn(1'b0);
    seen_warn = 0; seen_to = 0;
    for (int n = 0; n < 200 && !seen_to; n++) begin
      prev_t = int'(T);
      tick();
      if (Warn && !seen_warn) begin
        seen_warn = 1;
        chk("seqB.warn_at_T", 32'(prev_t), WRN);
      end
      if (Timeout) begin
        seen_to = 1;
        chk("seqB.timeout_at_T", 32'(prev_t), LIM);
        chk("seqB.start_off", 32'(Start), 0);
      end
    end
    chk("seqB.timeout_seen", 32'(seen_to), 1);
    chk("seqB.warn_seen", 32'(seen_warn), 1);
    n_to = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (Timeout) n_to++;
      chk("seqB.expired_start", 32'(Start), 0);
    end
    chk("seqB.one_pulse", 32'(n_to), 0);
    chk("seqB.tot0", 32'(Total0), 0);

    // Press on the same cycle T reaches the limit.
    begin_turn(1'b1);
    wait_t(LIM, "seqC.tlim");
    PressValid = 1; LastPress = 1;
    tick();
    quiet();
    chk("seqC.timeout", 32'(Timeout), 1);
    chk("seqC.no_done", 32'(TurnDone), 0);
    chk("seqC.tot1", 32'(Total1), 10);
    chk("seqC.used", 32'(TimeUsed), 6);

    // Abort mid-run.
    begin_turn(1'b0);
    wait_t(3, "seqD.t3");
    Abort = 1;
    tick();
    quiet();
    chk("seqD.start", 32'(Start), 0);
    n_to = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (Timeout || Start) n_to++;
    end
    chk("seqD.quiet", 32'(n_to), 0);
    chk("seqD.tot1", 32'(Total1), 10);

    // Reset mid-run, with a fresh nonzero total.
    begin_turn(1'b0);
    wait_t(2, "seqE.t2");
    PressValid = 1; LastPress = 0;
    tick();
    quiet();
    chk("seqE.tot0", 32'(Total0), 2);
    tick();
    wait_t(3, "seqE.t3");
    #2 Rst = 0;
    #1 check_all("seqE.rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    Rst = 1;

    // ---------------- randomized vs reference model ----------------
    m_run = 0; m_clr = 0; e_ap = 0; e_used = 0; sum0 = 0; sum1 = 0;
    for (int i = 0; i < 3000; i++) begin
      TurnBegin  = ($urandom_range(39) == 0);
      TurnPlayer = 1'($urandom);
      PressValid = ($urandom_range(5) == 0);
      LastPress  = ($urandom_range(2) == 0);
      Abort      = ($urandom_range(99) == 0);
      ClrTotals  = ($urandom_range(79) == 0);
      model_step();
      tick();
      check_all($sformatf("rnd%0d", i), int'(m_run), e_warn, e_to, e_done, e_ap, e_used,
                sat(sum0, 24), sat(sum1, 24), sat(sum0, 4), sat(sum1, 4));
    end
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
